// File: rtl/matmul_pkg.sv
// Shared sizes, accumulator width helper, result record and FSM encoding
// for the matrix-multiply scheduler.
package matmul_pkg;

   localparam int DEF_ELEMENT_SIZE = 8;
   localparam int DEF_SIZE_A       = 32;
   localparam int DEF_SIZE_B       = 32;

   function automatic int acc_width(input int elem_size, input int len);
      return 2 * elem_size + $clog2(len);
   endfunction

   typedef struct packed {
      logic [$clog2(DEF_SIZE_A)-1:0]                        row;
      logic [$clog2(DEF_SIZE_B)-1:0]                        col;
      logic [acc_width(DEF_ELEMENT_SIZE, DEF_SIZE_A)-1:0]   data;
   } result_t;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

endpackage

// File: rtl/dot_product_pipe.sv
// Two-stage unsigned dot product: registered element products, then a
// registered sum. Valid and (row, col) tags ride alongside the data.
module dot_product_pipe
   import matmul_pkg::*;
#(
   parameter int ELEMENT_SIZE = DEF_ELEMENT_SIZE,
   parameter int LEN          = DEF_SIZE_A,
   parameter int RW           = $clog2(DEF_SIZE_A),
   parameter int CW           = $clog2(DEF_SIZE_B),
   parameter int AW           = acc_width(DEF_ELEMENT_SIZE, DEF_SIZE_A)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid_in,
   input  logic [RW-1:0]               row_in,
   input  logic [CW-1:0]               col_in,
   input  logic [LEN*ELEMENT_SIZE-1:0] a_vec,
   input  logic [LEN*ELEMENT_SIZE-1:0] b_vec,
   output logic                        valid_out,
   output logic [RW-1:0]               row_out,
   output logic [CW-1:0]               col_out,
   output logic [AW-1:0]               sum_out
);
   localparam int PW = 2 * ELEMENT_SIZE;

   logic [2:1]               vld_pipe_q, vld_pipe_d;
   logic [2:1][RW-1:0]       row_pipe_q, row_pipe_d;
   logic [2:1][CW-1:0]       col_pipe_q, col_pipe_d;
   logic [LEN-1:0][PW-1:0]   prod_q, prod_d;
   logic [AW-1:0]            sum_q, sum_d;

   always_comb begin
      vld_pipe_d = {vld_pipe_q[1], valid_in};
      row_pipe_d = {row_pipe_q[1], row_in};
      col_pipe_d = {col_pipe_q[1], col_in};
      for (int k = 0; k < LEN; k++)
         prod_d[k] = PW'(a_vec[ELEMENT_SIZE*(LEN-k)-1 -: ELEMENT_SIZE]) *
                     PW'(b_vec[ELEMENT_SIZE*(LEN-k)-1 -: ELEMENT_SIZE]);
      sum_d = '0;
      for (int k = 0; k < LEN; k++)
         sum_d = sum_d + AW'(prod_q[k]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe_q <= '0;
         row_pipe_q <= '0;
         col_pipe_q <= '0;
      end else begin
         vld_pipe_q <= vld_pipe_d;
         row_pipe_q <= row_pipe_d;
         col_pipe_q <= col_pipe_d;
      end
   end

   // Wide datapath needs no reset; validity is carried by vld_pipe_q.
   always_ff @(posedge clk) begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
   end

   assign valid_out = vld_pipe_q[2];
   assign row_out   = row_pipe_q[2];
   assign col_out   = col_pipe_q[2];
   assign sum_out   = sum_q;

endmodule

// File: rtl/matmul_scheduler.sv
// Walks every (row, col) pair of A*B, requests operands from the loader
// under a credit limit, computes dot products and queues tagged results.
module matmul_scheduler
   import matmul_pkg::*;
#(
   parameter int ELEMENT_SIZE = DEF_ELEMENT_SIZE,
   parameter int SIZE_A       = DEF_SIZE_A,
   parameter int SIZE_B       = DEF_SIZE_B,
   parameter int READ_LATENCY = 3,
   parameter int FIFO_DEPTH   = 8,
   localparam int RW = $clog2(SIZE_A),
   localparam int CW = $clog2(SIZE_B),
   localparam int AW = acc_width(ELEMENT_SIZE, SIZE_A)
) (
   input  logic                           inter_refclk,
   input  logic                           rst,
   input  logic                           start,
   output logic                           valid_request,
   output logic [RW-1:0]                  requested_a_row,
   output logic [CW-1:0]                  requested_b_col,
   input  logic                           valid_in,
   input  logic [RW-1:0]                  a_addr_in,
   input  logic [CW-1:0]                  b_addr_in,
   input  logic [SIZE_A*ELEMENT_SIZE-1:0] a_row_in,
   input  logic [SIZE_A*ELEMENT_SIZE-1:0] b_col_in,
   output logic                           result_valid,
   input  logic                           result_ready,
   output logic [RW-1:0]                  result_row,
   output logic [CW-1:0]                  result_col,
   output logic [AW-1:0]                  result_data,
   output logic                           busy,
   output logic                           done,
   output logic                           tag_error
);
   localparam int PTRW = $clog2(FIFO_DEPTH);
   localparam int CNTW = PTRW + 1;
   localparam logic [RW-1:0] LAST_ROW = RW'(SIZE_A - 1);
   localparam logic [CW-1:0] LAST_COL = CW'(SIZE_B - 1);

   if (FIFO_DEPTH < READ_LATENCY + 3 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("matmul_scheduler: FIFO_DEPTH must be a power of 2 and >= READ_LATENCY+3");
   end

   typedef struct packed {
      logic [RW-1:0] row;
      logic [CW-1:0] col;
      logic [AW-1:0] data;
   } entry_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_cnt_q, row_cnt_d, exp_row_q, exp_row_d, req_row_q, req_row_d;
   logic [CW-1:0]   col_cnt_q, col_cnt_d, exp_col_q, exp_col_d, req_col_q, req_col_d;
   logic            valid_request_q, valid_request_d;
   logic            done_q, done_d, tag_error_q, tag_error_d;
   logic [CNTW-1:0] credit_q, credit_d, count_q, count_d;
   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   entry_t          mem_q [FIFO_DEPTH];
   entry_t          head, push_entry;
   logic            issue, push, pop, last_pop, fifo_nempty, pipe_vld_in;
   logic [RW-1:0]   pipe_row;
   logic [CW-1:0]   pipe_col;
   logic [AW-1:0]   pipe_sum;

   // Responses seen while IDLE are stale and must not reach the FIFO.
   assign pipe_vld_in = valid_in && (state_q != IDLE);

   dot_product_pipe #(
      .ELEMENT_SIZE (ELEMENT_SIZE),
      .LEN          (SIZE_A),
      .RW           (RW),
      .CW           (CW),
      .AW           (AW)
   ) u_dot (
      .clk       (inter_refclk),
      .rst       (rst),
      .valid_in  (pipe_vld_in),
      .row_in    (a_addr_in),
      .col_in    (b_addr_in),
      .a_vec     (a_row_in),
      .b_vec     (b_col_in),
      .valid_out (push),
      .row_out   (pipe_row),
      .col_out   (pipe_col),
      .sum_out   (pipe_sum)
   );

   always_comb begin
      fifo_nempty = (count_q != '0);
      head        = mem_q[rd_ptr_q];
      pop         = fifo_nempty && result_ready;
      last_pop    = pop && (head.row == LAST_ROW) && (head.col == LAST_COL);
      push_entry  = '{row: pipe_row, col: pipe_col, data: pipe_sum};

      wr_ptr_d = wr_ptr_q + PTRW'(push);
      rd_ptr_d = rd_ptr_q + PTRW'(pop);
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      state_d         = state_q;
      row_cnt_d       = row_cnt_q;
      col_cnt_d       = col_cnt_q;
      exp_row_d       = exp_row_q;
      exp_col_d       = exp_col_q;
      req_row_d       = req_row_q;
      req_col_d       = req_col_q;
      tag_error_d     = tag_error_q;
      valid_request_d = 1'b0;
      done_d          = 1'b0;
      issue           = 1'b0;

      if (valid_in) begin
         if (state_q == IDLE) begin
            tag_error_d = 1'b1;
         end else begin
            if (a_addr_in != exp_row_q || b_addr_in != exp_col_q)
               tag_error_d = 1'b1;
            if (exp_col_q == LAST_COL) begin
               exp_col_d = '0;
               exp_row_d = (exp_row_q == LAST_ROW) ? '0 : exp_row_q + 1'b1;
            end else begin
               exp_col_d = exp_col_q + 1'b1;
            end
         end
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               tag_error_d = 1'b0;
               row_cnt_d   = '0;
               col_cnt_d   = '0;
               exp_row_d   = '0;
               exp_col_d   = '0;
            end
         end
         RUN: begin
            if (credit_q < CNTW'(FIFO_DEPTH)) begin
               issue           = 1'b1;
               valid_request_d = 1'b1;
               req_row_d       = row_cnt_q;
               req_col_d       = col_cnt_q;
               if (col_cnt_q == LAST_COL) begin
                  col_cnt_d = '0;
                  if (row_cnt_q == LAST_ROW) begin
                     row_cnt_d = '0;
                     state_d   = DRAIN;
                  end else begin
                     row_cnt_d = row_cnt_q + 1'b1;
                  end
               end else begin
                  col_cnt_d = col_cnt_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (last_pop) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Credit covers loader latency, pipeline and FIFO, so push never overflows.
      case ({issue, pop})
         2'b10:   credit_d = credit_q + 1'b1;
         2'b01:   credit_d = credit_q - 1'b1;
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge inter_refclk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         row_cnt_q       <= '0;
         col_cnt_q       <= '0;
         exp_row_q       <= '0;
         exp_col_q       <= '0;
         req_row_q       <= '0;
         req_col_q       <= '0;
         valid_request_q <= 1'b0;
         done_q          <= 1'b0;
         tag_error_q     <= 1'b0;
         credit_q        <= '0;
         count_q         <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
      end else begin
         state_q         <= state_d;
         row_cnt_q       <= row_cnt_d;
         col_cnt_q       <= col_cnt_d;
         exp_row_q       <= exp_row_d;
         exp_col_q       <= exp_col_d;
         req_row_q       <= req_row_d;
         req_col_q       <= req_col_d;
         valid_request_q <= valid_request_d;
         done_q          <= done_d;
         tag_error_q     <= tag_error_d;
         credit_q        <= credit_d;
         count_q         <= count_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
      end
   end

   always_ff @(posedge inter_refclk) begin
      if (push)
         mem_q[wr_ptr_q] <= push_entry;
   end

   assign valid_request   = valid_request_q;
   assign requested_a_row = req_row_q;
   assign requested_b_col = req_col_q;
   assign result_valid    = fifo_nempty;
   // Head fields are masked so stale FIFO contents never show after reset.
   assign result_row      = fifo_nempty ? head.row  : '0;
   assign result_col      = fifo_nempty ? head.col  : '0;
   assign result_data     = fifo_nempty ? head.data : '0;
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign tag_error       = tag_error_q;

endmodule

// File: tb/tb_matmul_scheduler.sv
// Directed bench for matmul_scheduler with a fixed-latency loader model.
module tb_matmul_scheduler;
   localparam int N  = 32;
   localparam int VW = N * 8;

   logic           inter_refclk = 1'b0;
   logic           rst, start, result_ready;
   logic           valid_request, result_valid, busy, done, tag_error;
   logic [4:0]     requested_a_row, requested_b_col, result_row, result_col;
   logic [20:0]    result_data;
   bit             valid_in;
   bit   [4:0]     a_addr_in, b_addr_in;
   bit   [VW-1:0]  a_row_in, b_col_in;

   matmul_scheduler dut (
      .inter_refclk    (inter_refclk),
      .rst             (rst),
      .start           (start),
      .valid_request   (valid_request),
      .requested_a_row (requested_a_row),
      .requested_b_col (requested_b_col),
      .valid_in        (valid_in),
      .a_addr_in       (a_addr_in),
      .b_addr_in       (b_addr_in),
      .a_row_in        (a_row_in),
      .b_col_in        (b_col_in),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_row      (result_row),
      .result_col      (result_col),
      .result_data     (result_data),
      .busy            (busy),
      .done            (done),
      .tag_error       (tag_error)
   );

   always #5 inter_refclk = ~inter_refclk;

   int cyc = 0;
   always @(posedge inter_refclk) cyc <= cyc + 1;

   // Loader model: samples requests on negedge, answers 3 cycles later.
   byte unsigned mat_a [N][N];
   byte unsigned mat_b [N][N];
   bit           corrupt_en = 1'b0;
   bit           lp_v [3];
   bit [4:0]     lp_r [3];
   bit [4:0]     lp_c [3];

   function automatic bit [VW-1:0] pack_a(input int r);
      bit [VW-1:0] v;
      for (int k = 0; k < N; k++) v[VW-1-8*k -: 8] = mat_a[r][k];
      return v;
   endfunction

   function automatic bit [VW-1:0] pack_b(input int c);
      bit [VW-1:0] v;
      for (int k = 0; k < N; k++) v[VW-1-8*k -: 8] = mat_b[k][c];
      return v;
   endfunction

   always @(negedge inter_refclk) begin
      valid_in  = lp_v[2];
      a_addr_in = lp_r[2];
      b_addr_in = (corrupt_en && lp_r[2] == 5'd3 && lp_c[2] == 5'd5) ? 5'd6 : lp_c[2];
      a_row_in  = pack_a(int'(lp_r[2]));
      b_col_in  = pack_b(int'(lp_c[2]));
      lp_v[2] = lp_v[1]; lp_r[2] = lp_r[1]; lp_c[2] = lp_c[1];
      lp_v[1] = lp_v[0]; lp_r[1] = lp_r[0]; lp_c[1] = lp_c[0];
      lp_v[0] = valid_request; lp_r[0] = requested_a_row; lp_c[0] = requested_b_col;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic load_mats(input bit identity);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = identity ? ((i == j) ? 8'd1 : 8'd0) : 8'd255;
            mat_b[i][j] = identity ? 8'd7 : 8'd255;
         end
   endtask

   int n_pops, order_err, data_err, issued, max_out, issued_at_hold;
   int first_req_cyc, first_val_cyc, last_pop_cyc, done_cyc;
   bit got_done, vld_at_hold;

   // Pulses start, runs one full pass and scoreboards every popped result.
   task automatic run_pass(input int exp_data, input int hold, input int restart_at);
      n_pops = 0; order_err = 0; data_err = 0; issued = 0; max_out = 0;
      issued_at_hold = -1; vld_at_hold = 1'b0; got_done = 1'b0;
      first_req_cyc = -1; first_val_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
      for (int k = 0; k < 4000; k++) begin
         @(negedge inter_refclk);
         start        = (k == 0) || (k == restart_at);
         result_ready = (k >= hold);
         if (k == hold) begin
            issued_at_hold = issued;
            vld_at_hold    = result_valid;
         end
         if (valid_request) begin
            if (issued == 0) first_req_cyc = cyc;
            issued++;
         end
         if (result_valid && first_val_cyc < 0) first_val_cyc = cyc;
         if (issued - n_pops > max_out) max_out = issued - n_pops;
         if (result_valid && result_ready) begin
            if (int'(result_row) != n_pops / N || int'(result_col) != n_pops % N) order_err++;
            if (int'(result_data) != exp_data) data_err++;
            n_pops++;
            last_pop_cyc = cyc;
         end
         if (done) begin
            done_cyc = cyc;
            got_done = 1'b1;
            break;
         end
      end
      start = 1'b0;
      chk("pass_done_seen", got_done, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; result_ready = 1'b0;
      #2;
      chk("rst_valid_request", valid_request, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_tag_error", tag_error, 0);
      chk("rst_result_data", result_data, 0);
      @(negedge inter_refclk); rst = 1'b0; result_ready = 1'b1;
      repeat (3) @(negedge inter_refclk);
      chk("empty_pop_ignored", result_valid, 0);
      chk("idle_busy", busy, 0);

      // identity * 7s, ready high
      load_mats(1'b1);
      run_pass(7, 0, -1);
      chk("t1_pops", n_pops, 1024);
      chk("t1_order_err", order_err, 0);
      chk("t1_data_err", data_err, 0);
      chk("t1_first_latency", first_val_cyc - first_req_cyc, 6);
      chk("t1_throughput", last_pop_cyc - first_req_cyc, 1029);
      chk("t1_done_after_pop", done_cyc - last_pop_cyc, 1);
      chk("t1_max_credit", max_out <= 8, 1);
      chk("t1_busy_idle", busy, 0);
      @(negedge inter_refclk);
      chk("t1_done_width", done, 0);
      chk("t1_tag_error", tag_error, 0);

      // all 255s: widest sum
      load_mats(1'b0);
      run_pass(2080800, 0, -1);
      chk("t2_pops", n_pops, 1024);
      chk("t2_order_err", order_err, 0);
      chk("t2_data_err", data_err, 0);

      // backpressure: ready held low for the first 60 cycles
      run_pass(2080800, 60, -1);
      chk("t3_issued_at_hold", issued_at_hold, 8);
      chk("t3_valid_at_hold", vld_at_hold, 1);
      chk("t3_max_credit", max_out, 8);
      chk("t3_pops", n_pops, 1024);
      chk("t3_order_err", order_err, 0);
      chk("t3_data_err", data_err, 0);

      // start pulsed again mid-RUN
      run_pass(2080800, 0, 200);
      chk("t4_pops", n_pops, 1024);
      chk("t4_issued", issued, 1024);
      chk("t4_order_err", order_err, 0);
      chk("t4_data_err", data_err, 0);

      // one corrupted b_addr_in tag on (3,5)
      corrupt_en = 1'b1;
      run_pass(2080800, 0, -1);
      corrupt_en = 1'b0;
      chk("t5_tag_error", tag_error, 1);
      chk("t5_order_err", order_err, 1);
      chk("t5_pops", n_pops, 1024);
      repeat (5) @(negedge inter_refclk);
      chk("t5_tag_error_sticky", tag_error, 1);

      // fresh start clears the error, then async reset at request 500
      start = 1'b1; @(negedge inter_refclk); start = 1'b0;
      @(negedge inter_refclk);
      chk("t6_start_clears_err", tag_error, 0);
      issued = 0;
      for (int k = 0; k < 2000 && issued < 500; k++) begin
         if (valid_request) issued++;
         if (issued < 500) @(negedge inter_refclk);
      end
      chk("t6_reached_500", issued, 500);
      #2 rst = 1'b1;
      #1;
      chk("t6_rst_valid_request", valid_request, 0);
      chk("t6_rst_req_row", requested_a_row, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_result_valid", result_valid, 0);
      chk("t6_rst_result_data", result_data, 0);
      chk("t6_rst_done", done, 0);
      @(negedge inter_refclk); rst = 1'b0;
      repeat (4) @(negedge inter_refclk);
      chk("t6_late_valid_err", tag_error, 1);
      run_pass(2080800, 0, -1);
      chk("t6_pops", n_pops, 1024);
      chk("t6_order_err", order_err, 0);
      chk("t6_data_err", data_err, 0);
      chk("t6_tag_error", tag_error, 0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end
endmodule
